vend_txn_ctrl: RTL and testbench
================================

// Module: vend_txn_ctrl
// PURPOSE
//  Multi-slot vending transaction controller; supersedes the single-product purchase check.
//  Accumulates coins into a credit register, validates a (slot, qty) selection against
//  per-slot price/stock tables, then runs a dispense handshake, a change return and a bank update.
//  Maintenance mode (mode=0) loads prices and restocks slots. Sits between the coin/keypad
//  front end and the dispenser motor driver.
// PARAMETERS
//  NUM_SLOTS  4   number of product slots (>=2); SLOT_W = $clog2(NUM_SLOTS)
//  MONEY_W    8   width of credit, coin value, price and change
//  QTY_W      4   width of quantity and per-slot stock
//  BANK_W     11  width of machine bank (cash-box) accumulator
// PORTS
//  clk            in   1                 rising-edge clock
//  rst_n          in   1                 synchronous reset, active low
//  mode           in   1                 1=customer, 0=maintenance
//  coin_valid     in   1                 1-cycle coin strobe
//  coin_value     in   MONEY_W           value of inserted coin
//  sel_valid      in   1                 1-cycle selection strobe
//  sel_slot       in   SLOT_W            selected slot
//  sel_qty        in   QTY_W             requested quantity
//  cancel         in   1                 abort; refund credit
//  cfg_wr         in   1                 maintenance write strobe
//  cfg_slot       in   SLOT_W            slot addressed by cfg_wr
//  cfg_price      in   MONEY_W           new price for cfg_slot
//  cfg_restock    in   QTY_W             units added to cfg_slot
//  dispense_ack   in   1                 dispenser finished
//  dispense_valid out  1                 dispense request, held until ack
//  dispense_slot  out  SLOT_W            slot to dispense
//  dispense_qty   out  QTY_W             units to dispense
//  change_valid   out  1                 1-cycle change pulse
//  change_amount  out  MONEY_W           change value (valid with change_valid)
//  coin_reject    out  1                 1-cycle: coin refused
//  credit         out  MONEY_W           current credit
//  bank           out  BANK_W            machine money total
//  supply_flat    out  NUM_SLOTS*QTY_W   per-slot stock, slot 0 in LSBs
//  redlight       out  1                 last selection refused; sticky
//  busy           out  1                 state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; credit, bank, all stock, all prices, all outputs=0.
//   Reset mid-transaction discards credit without a change pulse.
//  FSM: IDLE -> CHECK -> DISPENSE -> CHANGE -> IDLE.
//   IDLE: coins accumulate; a valid sel_valid latches slot/qty and moves to CHECK (next cycle).
//   CHECK (1 cycle): total = price[slot]*qty at MONEY_W+QTY_W bits. Pass iff qty!=0,
//    stock>=qty, credit>=total, and bank+total <= 2^BANK_W-1. On pass, redlight<=0 and
//    state->DISPENSE. On fail, redlight<=1, state->IDLE, credit kept.
//   DISPENSE: dispense_valid=1 with slot/qty stable until the cycle dispense_ack=1 is seen.
//    On that cycle: stock-=qty; bank+=total; state->CHANGE.
//   CHANGE (1 cycle): change_valid=1, change_amount=credit-total; credit<=0; state->IDLE.
//  Latency: sel_valid at cycle t gives dispense_valid at t+2; change at ack+1.
//  Coins: accepted only in IDLE with mode=1. Overflow (credit+coin > 2^MONEY_W-1) is refused.
//   Coins in any other state or mode are also refused: coin_reject=1 and credit unchanged.
//  cancel: in IDLE with credit>0, emit change_valid for the full credit and clear credit.
//   In CHECK or later, cancel is ignored. cancel+coin in the same cycle: cancel wins, coin rejected.
//  sel_valid is ignored outside IDLE, when mode=0, or with sel_slot>=NUM_SLOTS.
//  redlight clears on the next accepted coin or on a passing CHECK.
//  cfg_wr: acted on only when mode=0 and state=IDLE, else ignored. price<=cfg_price;
//   stock<=min(stock+cfg_restock, 2^QTY_W-1), saturating.
//  Mode change mid-transaction does not abort it; the FSM completes first.
//  busy=1 in every state except IDLE.
// STRUCTURE
//  Package vend_pkg: state enum {IDLE,CHECK,DISPENSE,CHANGE}; default widths as localparams.
//  Sub-module vend_slot_table: per-slot price/stock register file with a read port,
//   a saturating restock write port and a decrement port. The FSM, credit and bank live in
//   vend_txn_ctrl.
// TESTING
//  1. price[1]=3,stock[1]=5; coins 5+5; sel(1,2) -> dispense(1,2) t+2; ack -> change 4, bank 6, stock 3
//  2. credit 4, price[0]=3, sel(0,2) -> redlight=1, IDLE, credit stays 4, no dispense
//  3. stock[2]=1, ample credit, sel(2,3) -> redlight; then sel(2,1) -> dispense, redlight=0
//  4. credit 250 (MONEY_W=8), coin 10 -> coin_reject, credit 250; cancel -> change 250, credit 0
//  5. mode=0, stock[3]=14, restock 5 -> stock 15; cfg_wr while busy -> no effect
//  6. rst_n=0 while dispense_valid=1 -> next cycle all outputs 0, no change pulse; ack ignored

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and default widths for the vending transaction controller.
package vend_pkg;

    localparam int unsigned DEF_NUM_SLOTS = 4;
    localparam int unsigned DEF_MONEY_W   = 8;
    localparam int unsigned DEF_QTY_W     = 4;
    localparam int unsigned DEF_BANK_W    = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

endpackage

// File: rtl/vend_slot_table.sv
// Per-slot price/stock register file: combinational read port, saturating
// restock write port and a stock decrement port.
module vend_slot_table
    import vend_pkg::*;
#(
    parameter int unsigned  NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int unsigned  MONEY_W   = DEF_MONEY_W,
    parameter int unsigned  QTY_W     = DEF_QTY_W,
    localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SLOT_W-1:0]          i_rd_slot,
    output logic [MONEY_W-1:0]         o_rd_price_c,
    output logic [QTY_W-1:0]           o_rd_stock_c,
    input  logic                       i_wr_en,
    input  logic [SLOT_W-1:0]          i_wr_slot,
    input  logic [MONEY_W-1:0]         i_wr_price,
    input  logic [QTY_W-1:0]           i_wr_restock,
    input  logic                       i_dec_en,
    input  logic [SLOT_W-1:0]          i_dec_slot,
    input  logic [QTY_W-1:0]           i_dec_qty,
    output logic [NUM_SLOTS*QTY_W-1:0] o_supply_flat
);

    logic [MONEY_W-1:0] r_price [NUM_SLOTS];
    logic [QTY_W-1:0]   r_stock [NUM_SLOTS];
    logic [QTY_W:0]     w_restock_sum;

    assign o_rd_price_c  = r_price[i_rd_slot];
    assign o_rd_stock_c  = r_stock[i_rd_slot];
    assign w_restock_sum = (QTY_W+1)'(r_stock[i_wr_slot]) + (QTY_W+1)'(i_wr_restock);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                r_price[i] <= '0;
                r_stock[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_price[i_wr_slot] <= i_wr_price;
            r_stock[i_wr_slot] <= w_restock_sum[QTY_W] ? '1 : w_restock_sum[QTY_W-1:0];
        end else if (i_dec_en) begin
            r_stock[i_dec_slot] <= r_stock[i_dec_slot] - i_dec_qty;
        end
    end

    always_comb begin
        o_supply_flat = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            o_supply_flat[i*QTY_W +: QTY_W] = r_stock[i];
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Multi-slot vending transaction controller: credit accumulation, selection
// check, dispense handshake, change return and bank update.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned  NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int unsigned  MONEY_W   = DEF_MONEY_W,
    parameter int unsigned  QTY_W     = DEF_QTY_W,
    parameter int unsigned  BANK_W    = DEF_BANK_W,
    localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode,
    input  logic                       coin_valid,
    input  logic [MONEY_W-1:0]         coin_value,
    input  logic                       sel_valid,
    input  logic [SLOT_W-1:0]          sel_slot,
    input  logic [QTY_W-1:0]           sel_qty,
    input  logic                       cancel,
    input  logic                       cfg_wr,
    input  logic [SLOT_W-1:0]          cfg_slot,
    input  logic [MONEY_W-1:0]         cfg_price,
    input  logic [QTY_W-1:0]           cfg_restock,
    input  logic                       dispense_ack,
    output logic                       dispense_valid,
    output logic [SLOT_W-1:0]          dispense_slot,
    output logic [QTY_W-1:0]           dispense_qty,
    output logic                       change_valid,
    output logic [MONEY_W-1:0]         change_amount,
    output logic                       coin_reject,
    output logic [MONEY_W-1:0]         credit,
    output logic [BANK_W-1:0]          bank,
    output logic [NUM_SLOTS*QTY_W-1:0] supply_flat,
    output logic                       redlight,
    output logic                       busy
);

    localparam int unsigned TOT_W = MONEY_W + QTY_W;
    localparam int unsigned SUM_W = ((BANK_W > TOT_W) ? BANK_W : TOT_W) + 1;

    state_t             r_state, w_state_nxt;
    logic [MONEY_W-1:0] r_credit, w_credit_nxt;
    logic [BANK_W-1:0]  r_bank, w_bank_nxt;
    logic [SLOT_W-1:0]  r_slot, w_slot_nxt;
    logic [QTY_W-1:0]   r_qty, w_qty_nxt;
    logic [MONEY_W-1:0] r_total, w_total_nxt;
    logic               r_redlight, w_redlight_nxt;
    logic               r_disp_valid, w_disp_valid_nxt;
    logic               r_chg_valid, w_chg_valid_nxt;
    logic [MONEY_W-1:0] r_chg_amount, w_chg_amount_nxt;
    logic               r_coin_reject, w_coin_reject_nxt;
    logic               r_busy;

    logic               w_cfg_en;
    logic               w_dec_en;
    logic [MONEY_W-1:0] w_rd_price;
    logic [QTY_W-1:0]   w_rd_stock;
    logic [TOT_W-1:0]   w_total;
    logic [SUM_W-1:0]   w_bank_sum;
    logic [MONEY_W:0]   w_coin_sum;
    logic               w_sel_in_range;
    logic               w_pass;

    vend_slot_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .MONEY_W   (MONEY_W),
        .QTY_W     (QTY_W)
    ) u_slot_table (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rd_slot     (r_slot),
        .o_rd_price_c  (w_rd_price),
        .o_rd_stock_c  (w_rd_stock),
        .i_wr_en       (w_cfg_en),
        .i_wr_slot     (cfg_slot),
        .i_wr_price    (cfg_price),
        .i_wr_restock  (cfg_restock),
        .i_dec_en      (w_dec_en),
        .i_dec_slot    (r_slot),
        .i_dec_qty     (r_qty),
        .o_supply_flat (supply_flat)
    );

    // Purchase check operands for the latched selection
    assign w_total        = TOT_W'(w_rd_price) * TOT_W'(r_qty);
    assign w_bank_sum     = SUM_W'(r_bank) + SUM_W'(w_total);
    assign w_coin_sum     = (MONEY_W+1)'(r_credit) + (MONEY_W+1)'(coin_value);
    assign w_sel_in_range = {1'b0, sel_slot} < (SLOT_W+1)'(NUM_SLOTS);
    assign w_pass         = (r_qty != '0) && (w_rd_stock >= r_qty) &&
                            (TOT_W'(r_credit) >= w_total) &&
                            (w_bank_sum <= SUM_W'({BANK_W{1'b1}}));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_bank        <= '0;
            r_slot        <= '0;
            r_qty         <= '0;
            r_total       <= '0;
            r_redlight    <= 1'b0;
            r_disp_valid  <= 1'b0;
            r_chg_valid   <= 1'b0;
            r_chg_amount  <= '0;
            r_coin_reject <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_bank        <= w_bank_nxt;
            r_slot        <= w_slot_nxt;
            r_qty         <= w_qty_nxt;
            r_total       <= w_total_nxt;
            r_redlight    <= w_redlight_nxt;
            r_disp_valid  <= w_disp_valid_nxt;
            r_chg_valid   <= w_chg_valid_nxt;
            r_chg_amount  <= w_chg_amount_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_bank_nxt        = r_bank;
        w_slot_nxt        = r_slot;
        w_qty_nxt         = r_qty;
        w_total_nxt       = r_total;
        w_redlight_nxt    = r_redlight;
        w_disp_valid_nxt  = 1'b0;
        w_chg_valid_nxt   = 1'b0;
        w_chg_amount_nxt  = '0;
        w_coin_reject_nxt = coin_valid;
        w_cfg_en          = 1'b0;
        w_dec_en          = 1'b0;
        case (r_state)
            IDLE: begin
                w_cfg_en = cfg_wr && !mode;
                // cancel outranks both a coin and a selection in the same cycle
                if (cancel) begin
                    if (r_credit != '0) begin
                        w_chg_valid_nxt  = 1'b1;
                        w_chg_amount_nxt = r_credit;
                        w_credit_nxt     = '0;
                    end
                end else begin
                    if (coin_valid && mode && !w_coin_sum[MONEY_W]) begin
                        w_coin_reject_nxt = 1'b0;
                        w_credit_nxt      = w_coin_sum[MONEY_W-1:0];
                        w_redlight_nxt    = 1'b0;
                    end
                    if (sel_valid && mode && w_sel_in_range) begin
                        w_slot_nxt  = sel_slot;
                        w_qty_nxt   = sel_qty;
                        w_state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (w_pass) begin
                    w_redlight_nxt   = 1'b0;
                    w_total_nxt      = MONEY_W'(w_total);
                    w_disp_valid_nxt = 1'b1;
                    w_state_nxt      = DISPENSE;
                end else begin
                    w_redlight_nxt = 1'b1;
                    w_state_nxt    = IDLE;
                end
            end
            DISPENSE: begin
                w_disp_valid_nxt = 1'b1;
                if (dispense_ack) begin
                    w_disp_valid_nxt = 1'b0;
                    w_dec_en         = 1'b1;
                    w_bank_nxt       = r_bank + BANK_W'(r_total);
                    w_chg_valid_nxt  = 1'b1;
                    w_chg_amount_nxt = r_credit - r_total;
                    w_state_nxt      = CHANGE;
                end
            end
            CHANGE: begin
                w_credit_nxt = '0;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign dispense_valid = r_disp_valid;
    assign dispense_slot  = r_slot;
    assign dispense_qty   = r_qty;
    assign change_valid   = r_chg_valid;
    assign change_amount  = r_chg_amount;
    assign coin_reject    = r_coin_reject;
    assign credit         = r_credit;
    assign bank           = r_bank;
    assign redlight       = r_redlight;
    assign busy           = r_busy;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed self-checking bench for vend_txn_ctrl with hand-computed expectations.
module tb_vend_txn_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        coin_valid;
    logic [7:0]  coin_value;
    logic        sel_valid;
    logic [1:0]  sel_slot;
    logic [3:0]  sel_qty;
    logic        cancel;
    logic        cfg_wr;
    logic [1:0]  cfg_slot;
    logic [7:0]  cfg_price;
    logic [3:0]  cfg_restock;
    logic        dispense_ack;
    logic        dispense_valid;
    logic [1:0]  dispense_slot;
    logic [3:0]  dispense_qty;
    logic        change_valid;
    logic [7:0]  change_amount;
    logic        coin_reject;
    logic [7:0]  credit;
    logic [10:0] bank;
    logic [15:0] supply_flat;
    logic        redlight;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    vend_txn_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode           (mode),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .sel_valid      (sel_valid),
        .sel_slot       (sel_slot),
        .sel_qty        (sel_qty),
        .cancel         (cancel),
        .cfg_wr         (cfg_wr),
        .cfg_slot       (cfg_slot),
        .cfg_price      (cfg_price),
        .cfg_restock    (cfg_restock),
        .dispense_ack   (dispense_ack),
        .dispense_valid (dispense_valid),
        .dispense_slot  (dispense_slot),
        .dispense_qty   (dispense_qty),
        .change_valid   (change_valid),
        .change_amount  (change_amount),
        .coin_reject    (coin_reject),
        .credit         (credit),
        .bank           (bank),
        .supply_flat    (supply_flat),
        .redlight       (redlight),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [1:0] s, input logic [7:0] p, input logic [3:0] r);
        cfg_wr = 1'b1; cfg_slot = s; cfg_price = p; cfg_restock = r;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic do_coin(input logic [7:0] v);
        coin_valid = 1'b1; coin_value = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic do_sel(input logic [1:0] s, input logic [3:0] q);
        sel_valid = 1'b1; sel_slot = s; sel_qty = q;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_ack();
        dispense_ack = 1'b1;
        tick();
        dispense_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b1; coin_valid = 1'b0; coin_value = '0;
        sel_valid = 1'b0; sel_slot = '0; sel_qty = '0; cancel = 1'b0;
        cfg_wr = 1'b0; cfg_slot = '0; cfg_price = '0; cfg_restock = '0;
        dispense_ack = 1'b0;
        tick(); tick();
        check("rst_credit", 32'(credit), 0);
        check("rst_bank", 32'(bank), 0);
        check("rst_supply", 32'(supply_flat), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dv", 32'(dispense_valid), 0);
        rst_n = 1'b1;
        tick();

        // 1: normal purchase with change
        mode = 1'b0;
        do_cfg(2'd1, 8'd3, 4'd5);
        check("t1_stock1_cfg", 32'(supply_flat[7:4]), 5);
        mode = 1'b1;
        do_coin(8'd5);
        do_coin(8'd5);
        check("t1_credit", 32'(credit), 10);
        do_sel(2'd1, 4'd2);
        check("t1_busy_check", 32'(busy), 1);
        check("t1_dv_t1", 32'(dispense_valid), 0);
        tick();
        check("t1_dv_t2", 32'(dispense_valid), 1);
        check("t1_dslot", 32'(dispense_slot), 1);
        check("t1_dqty", 32'(dispense_qty), 2);
        tick();
        check("t1_dv_hold", 32'(dispense_valid), 1);
        do_ack();
        check("t1_chg_valid", 32'(change_valid), 1);
        check("t1_chg_amt", 32'(change_amount), 4);
        check("t1_bank", 32'(bank), 6);
        check("t1_stock1", 32'(supply_flat[7:4]), 3);
        check("t1_dv_off", 32'(dispense_valid), 0);
        tick();
        check("t1_chg_pulse", 32'(change_valid), 0);
        check("t1_credit0", 32'(credit), 0);
        check("t1_idle", 32'(busy), 0);

        // 2: insufficient credit
        mode = 1'b0;
        do_cfg(2'd0, 8'd3, 4'd5);
        mode = 1'b1;
        do_coin(8'd4);
        do_sel(2'd0, 4'd2);
        tick();
        check("t2_red", 32'(redlight), 1);
        check("t2_busy", 32'(busy), 0);
        check("t2_credit", 32'(credit), 4);
        check("t2_dv", 32'(dispense_valid), 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t2_cancel_chg", 32'(change_valid), 1);
        check("t2_cancel_amt", 32'(change_amount), 4);
        check("t2_cancel_credit", 32'(credit), 0);

        // 3: stock shortfall, zero quantity, then a good selection
        mode = 1'b0;
        do_cfg(2'd2, 8'd2, 4'd1);
        mode = 1'b1;
        do_coin(8'd20);
        check("t3_red_clr_coin", 32'(redlight), 0);
        do_sel(2'd2, 4'd0);
        tick();
        check("t3_red_qty0", 32'(redlight), 1);
        do_sel(2'd2, 4'd3);
        tick();
        check("t3_red_stock", 32'(redlight), 1);
        check("t3_credit", 32'(credit), 20);
        do_sel(2'd2, 4'd1);
        tick();
        check("t3_dv", 32'(dispense_valid), 1);
        check("t3_red_clr", 32'(redlight), 0);
        do_ack();
        check("t3_chg_amt", 32'(change_amount), 18);
        check("t3_bank", 32'(bank), 8);
        check("t3_stock2", 32'(supply_flat[11:8]), 0);
        tick();

        // 4: credit overflow, cancel, cancel+coin, maintenance coin
        do_coin(8'd200);
        do_coin(8'd50);
        check("t4_credit250", 32'(credit), 250);
        check("t4_accept", 32'(coin_reject), 0);
        do_coin(8'd10);
        check("t4_reject", 32'(coin_reject), 1);
        check("t4_credit_kept", 32'(credit), 250);
        tick();
        check("t4_reject_pulse", 32'(coin_reject), 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t4_cancel_chg", 32'(change_valid), 1);
        check("t4_cancel_amt", 32'(change_amount), 250);
        check("t4_cancel_credit", 32'(credit), 0);
        cancel = 1'b1;
        do_coin(8'd5);
        cancel = 1'b0;
        check("t4_cc_reject", 32'(coin_reject), 1);
        check("t4_cc_credit", 32'(credit), 0);
        check("t4_cc_nochg", 32'(change_valid), 0);
        mode = 1'b0;
        do_coin(8'd5);
        check("t4_mode0_reject", 32'(coin_reject), 1);
        check("t4_mode0_credit", 32'(credit), 0);

        // 5: saturating restock, cfg_wr and coins ignored while busy
        do_cfg(2'd3, 8'd7, 4'd14);
        check("t5_stock14", 32'(supply_flat[15:12]), 14);
        do_cfg(2'd3, 8'd7, 4'd5);
        check("t5_stock_sat", 32'(supply_flat[15:12]), 15);
        mode = 1'b1;
        do_coin(8'd3);
        do_sel(2'd1, 4'd1);
        mode = 1'b0;
        tick();
        check("t5_dv", 32'(dispense_valid), 1);
        do_cfg(2'd1, 8'd9, 4'd4);
        check("t5_cfg_ignored", 32'(supply_flat[7:4]), 3);
        do_coin(8'd1);
        check("t5_busy_coin_rej", 32'(coin_reject), 1);
        check("t5_busy_credit", 32'(credit), 3);
        do_ack();
        check("t5_chg_amt", 32'(change_amount), 0);
        check("t5_chg_valid", 32'(change_valid), 1);
        check("t5_stock1", 32'(supply_flat[7:4]), 2);
        check("t5_bank", 32'(bank), 11);
        tick();
        mode = 1'b1;
        do_coin(8'd3);
        do_sel(2'd1, 4'd1);
        tick();
        check("t5_price_kept", 32'(dispense_valid), 1);

        // 6: reset while dispensing
        rst_n = 1'b0;
        tick();
        check("t6_dv", 32'(dispense_valid), 0);
        check("t6_credit", 32'(credit), 0);
        check("t6_bank", 32'(bank), 0);
        check("t6_supply", 32'(supply_flat), 0);
        check("t6_chg", 32'(change_valid), 0);
        check("t6_busy", 32'(busy), 0);
        rst_n = 1'b1;
        do_ack();
        check("t6_ack_chg", 32'(change_valid), 0);
        check("t6_ack_bank", 32'(bank), 0);
        check("t6_ack_busy", 32'(busy), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
